mac_multiplex_1: RTL and testbench



---
 rtl/mac_multiplex_pkg.sv | 39 +++
 rtl/mac_mult_4x4.sv | 14 +
 rtl/mac_multiplex_1.sv | 49 ++++
 tb/tb_mac_multiplex_1.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mac_multiplex_pkg.sv
// mac_multiplex_pkg: widths, mode enum and packed-accumulator pack/unpack helpers shared by the MAC and its checker
package mac_multiplex_pkg;
  localparam int W_WIDTH = 8;
  localparam int A_WIDTH = 8;
  localparam int PLUS_WIDTH = 4;
  localparam int CONFIG_AW_WIDTH = 1;
  localparam int Z_WIDTH = W_WIDTH + A_WIDTH + 2 * PLUS_WIDTH;
  localparam int LANE_Z = Z_WIDTH / 2;
  localparam int ACC0_WIDTH = W_WIDTH + A_WIDTH + PLUS_WIDTH;
  localparam int LOW0 = ACC0_WIDTH - LANE_Z;
  localparam int PP_WIDTH = 9;
  typedef enum logic {MODE_8X8 = 1'b0, MODE_4X4 = 1'b1} mode_e;
  function automatic logic [ACC0_WIDTH-1:0] unpack_8x8(input logic [Z_WIDTH-1:0] v);
    return {v[Z_WIDTH-1:LANE_Z], v[LOW0-1:0]};
  endfunction
  function automatic logic [Z_WIDTH-1:0] pack_8x8(input logic [ACC0_WIDTH-1:0] v);
    return {v[ACC0_WIDTH-1:LOW0], {PLUS_WIDTH{1'b0}}, v[LOW0-1:0]};
  endfunction
  function automatic logic [LANE_Z-1:0] lane_of(input logic [Z_WIDTH-1:0] v, input logic hi);
    return hi ? v[Z_WIDTH-1:LANE_Z] : v[LANE_Z-1:0];
  endfunction
  function automatic logic [Z_WIDTH-1:0] pack_4x4(input logic [LANE_Z-1:0] l1, input logic [LANE_Z-1:0] l0);
    return {l1, l0};
  endfunction
  function automatic logic [ACC0_WIDTH-1:0] sx_acc(input logic [PP_WIDTH-1:0] v);
    return {{(ACC0_WIDTH-PP_WIDTH){v[PP_WIDTH-1]}}, v};
  endfunction
  function automatic logic [LANE_Z-1:0] sx_lane(input logic [PP_WIDTH-1:0] v);
    return {{(LANE_Z-PP_WIDTH){v[PP_WIDTH-1]}}, v};
  endfunction
  function automatic logic [Z_WIDTH-1:0] accumulate(input logic [Z_WIDTH-1:0] acc, input logic [Z_WIDTH-1:0] p, input mode_e m);
    logic [ACC0_WIDTH-1:0] s0;
    logic [LANE_Z-1:0] s1, s2;
    s0 = unpack_8x8(acc) + unpack_8x8(p);
    s1 = lane_of(acc, 1'b1) + lane_of(p, 1'b1);
    s2 = lane_of(acc, 1'b0) + lane_of(p, 1'b0);
    return m == MODE_8X8 ? pack_8x8(s0) : pack_4x4(s1, s2);
  endfunction
endpackage

// File: rtl/mac_mult_4x4.sv
// mac_mult_4x4: unsigned 4-bit a times (signed or unsigned) 4-bit w partial product, forced to 0 when en is low
module mac_mult_4x4 (
  input  logic [3:0]        a,
  input  logic [3:0]        w,
  input  logic              w_signed,
  input  logic              en,
  output logic signed [8:0] p
);
  logic signed [9:0] ax, wx, full;
  assign ax = {6'b0, a};
  assign wx = {{6{w_signed & w[3]}}, w};
  assign full = ax * wx;
  assign p = en ? full[8:0] : '0;
endmodule

// File: rtl/mac_multiplex_1.sv
// mac_multiplex_1: 8x8 or 2x(4x4) signed-weight MAC into packed 24-bit z; ports clk, rst (async low), accu_rst, config_aw, w, a -> z
module mac_multiplex_1
  import mac_multiplex_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               accu_rst,
  input  logic               config_aw,
  input  logic [W_WIDTH-1:0] w,
  input  logic [A_WIDTH-1:0] a,
  output logic [Z_WIDTH-1:0] z
);
  logic [W_WIDTH-1:0] w_q;
  logic [A_WIDTH-1:0] a_q;
  mode_e cfg_q, cfg_q2;
  logic clr_q, cross_en, lo_signed;
  logic signed [8:0] p_ll, p_hl, p_lh, p_hh;
  logic [ACC0_WIDTH-1:0] p_full;
  logic [Z_WIDTH-1:0] prod_d, prod_q;
  assign cross_en = cfg_q == MODE_8X8;
  assign lo_signed = cfg_q == MODE_4X4;
  mac_mult_4x4 u_ll (.a(a_q[3:0]), .w(w_q[3:0]), .w_signed(lo_signed), .en(1'b1), .p(p_ll));
  mac_mult_4x4 u_hl (.a(a_q[7:4]), .w(w_q[3:0]), .w_signed(1'b0), .en(cross_en), .p(p_hl));
  mac_mult_4x4 u_lh (.a(a_q[3:0]), .w(w_q[7:4]), .w_signed(1'b1), .en(cross_en), .p(p_lh));
  mac_mult_4x4 u_hh (.a(a_q[7:4]), .w(w_q[7:4]), .w_signed(1'b1), .en(1'b1), .p(p_hh));
  always_comb begin
    p_full = sx_acc(p_ll) + (sx_acc(p_hl) << 4) + (sx_acc(p_lh) << 4) + (sx_acc(p_hh) << 8);
    prod_d = cfg_q == MODE_8X8 ? pack_8x8(p_full) : pack_4x4(sx_lane(p_hh), sx_lane(p_ll));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q <= '0;
      a_q <= '0;
      cfg_q <= MODE_8X8;
      cfg_q2 <= MODE_8X8;
      clr_q <= 1'b0;
      prod_q <= '0;
      z <= '0;
    end else begin
      w_q <= w;
      a_q <= a;
      cfg_q <= mode_e'(config_aw);
      clr_q <= accu_rst;
      prod_q <= prod_d;
      cfg_q2 <= cfg_q;
      z <= clr_q ? '0 : accumulate(z, prod_q, cfg_q2);
    end
  end
endmodule

// File: tb/tb_mac_multiplex_1.sv
// tb_mac_multiplex_1: scoreboard bench for mac_multiplex_1 with directed vectors
module tb_mac_multiplex_1;
  logic clk = 1'b0;
  logic rst, accu_rst, config_aw;
  logic [7:0] w, a;
  logic [23:0] z;
  typedef struct {
    int e;
    logic [23:0] v;
    string nm;
  } exp_t;
  exp_t sb[$];
  exp_t ent;
  int edge_n = 0;
  int c = 0;
  int checks = 0;
  int errors = 0;
  mac_multiplex_1 dut (.clk(clk), .rst(rst), .accu_rst(accu_rst), .config_aw(config_aw), .w(w), .a(a), .z(z));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    edge_n++;
    while (sb.size() > 0 && sb[0].e <= edge_n) begin
      ent = sb.pop_front();
      checks++;
      if (ent.e != edge_n || z !== ent.v) begin
        errors++;
        $display("FAIL %s: z=%h at edge %0d, required %h at edge %0d", ent.nm, z, edge_n, ent.v, ent.e);
      end
    end
  end
  task automatic push_exp(input int e, input logic [23:0] v, input string nm);
    sb.push_back('{e, v, nm});
  endtask
  task automatic step(input logic clr, input logic cfg, input logic [7:0] av, input logic [7:0] wv);
    @(negedge clk);
    accu_rst = clr;
    config_aw = cfg;
    a = av;
    w = wv;
    c = edge_n + 1;
  endtask
  task automatic quiet(input logic cfg, input logic [23:0] v, input string nm);
    step(1'b0, cfg, 8'h00, 8'h00);
    step(1'b0, cfg, 8'h00, 8'h00);
    push_exp(c + 1, v, nm);
  endtask
  task automatic direct(input logic [23:0] v, input string nm);
    checks++;
    if (z !== v) begin
      errors++;
      $display("FAIL %s: z=%h required %h", nm, z, v);
    end
  endtask
  initial begin
    rst = 1'b0;
    accu_rst = 1'b0;
    config_aw = 1'b0;
    a = '0;
    w = '0;
    #12;
    direct(24'h000000, "reset_value");
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'd3, 8'd5);
    push_exp(c + 1, 24'h000000, "m0_clear");
    push_exp(c + 2, 24'h00000F, "m0_term1");
    step(1'b0, 1'b0, 8'd10, 8'hFE);
    push_exp(c + 2, 24'hFFF0FB, "m0_term2");
    quiet(1'b0, 24'hFFF0FB, "m0_hold");
    step(1'b1, 1'b1, 8'hF2, 8'h73);
    push_exp(c + 1, 24'h000000, "m1_clear");
    push_exp(c + 2, 24'h069006, "m1_term1");
    step(1'b0, 1'b1, 8'h1F, 8'h8F);
    push_exp(c + 2, 24'h061FF7, "m1_term2");
    quiet(1'b1, 24'h061FF7, "m1_hold");
    step(1'b1, 1'b1, 8'h00, 8'h00);
    push_exp(c + 1, 24'h000000, "lane_clear");
    step(1'b0, 1'b1, 8'h0F, 8'h08);
    push_exp(c + 2, 24'h000F88, "lane_first");
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h0F, 8'h08);
    push_exp(c + 2, 24'h000790, "lane_wrap18");
    quiet(1'b1, 24'h000790, "lane_hold");
    step(1'b1, 1'b0, 8'hFF, 8'h80);
    push_exp(c + 1, 24'h000000, "ext_clear");
    push_exp(c + 2, 24'hF80080, "ext_first");
    for (int i = 0; i < 39; i++) step(1'b0, 1'b0, 8'hFF, 8'h80);
    push_exp(c + 2, 24'hC14000, "ext_sum40");
    quiet(1'b0, 24'hC14000, "ext_hold");
    step(1'b1, 1'b0, 8'd2, 8'd3);
    push_exp(c + 1, 24'h000000, "mid_clear0");
    push_exp(c + 2, 24'h000006, "mid_term1");
    step(1'b0, 1'b0, 8'd2, 8'd3);
    push_exp(c + 2, 24'h00000C, "mid_term2");
    step(1'b0, 1'b0, 8'd2, 8'd3);
    step(1'b1, 1'b0, 8'd1, 8'd1);
    push_exp(c + 1, 24'h000000, "mid_clear");
    push_exp(c + 2, 24'h000001, "mid_restart");
    quiet(1'b0, 24'h000001, "mid_hold");
    step(1'b1, 1'b0, 8'd2, 8'd3);
    push_exp(c + 1, 24'h000000, "ar_clear");
    push_exp(c + 2, 24'h000006, "ar_term1");
    step(1'b0, 1'b0, 8'd2, 8'd3);
    step(1'b0, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    direct(24'h000000, "async_clear");
    @(negedge clk);
    direct(24'h000000, "async_held");
    rst = 1'b1;
    accu_rst = 1'b0;
    config_aw = 1'b0;
    a = 8'd2;
    w = 8'd3;
    c = edge_n + 1;
    push_exp(c + 1, 24'h000000, "ar_release_wait");
    push_exp(c + 2, 24'h000006, "ar_release_term");
    quiet(1'b0, 24'h000006, "ar_release_hold");
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
